// File: rtl/clb_cfg_pkg.sv
// Shared constants, field layout and FSM state type for the CLB configuration loader.
// Build option CLB_CFG_PARITY_EN appends an odd-parity bit to every frame.
package clb_cfg_pkg;

  localparam int CFG_W_DEF = 37;
  localparam int CNT_W_DEF = 8;

  localparam logic [7:0] PREAMBLE = 8'hB2;

`ifdef CLB_CFG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Field layout of the configuration word, LSB offsets; the mux-select field is sent first.
  localparam int FF_OFS    = 0;
  localparam int FF_W      = 1;
  localparam int COMB_OFS  = 1;
  localparam int COMB_W    = 2;
  localparam int LUT_OFS   = 3;
  localparam int LUT_W     = 16;
  localparam int DQ_OFS    = 19;
  localparam int DQ_W      = 2;
  localparam int INSEL_OFS = 21;
  localparam int INSEL_W   = 6;
  localparam int MUX_OFS   = 27;
  localparam int MUX_W     = 10;

  // Prefixed so the error state does not collide with the ERR port.
  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_FRAME,
    S_STALL,
    S_DRAIN,
    S_ERR
  } cfg_state_e;

endpackage

// File: rtl/clb_cfg_frame_shift.sv
// Frame deserialiser: data shift register, bit counter and running parity.
// With CLB_CFG_PARITY_EN the last bit of each frame is an odd-parity bit, not data.
module clb_cfg_frame_shift
  import clb_cfg_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             din,
  output logic             frame_done,
  output logic             parity_ok,
  output logic [CFG_W-1:0] frame_word,
  output logic [CFG_W-1:0] held_word
);

  localparam int FB = CFG_W + PAR_BITS;
  localparam int BW = $clog2(FB + 1);

  logic [BW-1:0]    bit_cnt_reg;
  logic [BW-1:0]    bit_cnt_next;
  logic [CFG_W-1:0] shift_reg;
  logic [CFG_W-1:0] shift_next;
  logic             last_bit;
  logic             data_en;

  genvar gi;
  assign shift_next[0] = din;
  generate
    for (gi = 1; gi < CFG_W; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi-1];
    end
  endgenerate

  assign last_bit     = (bit_cnt_reg == BW'(FB - 1));
  assign bit_cnt_next = last_bit ? '0 : bit_cnt_reg + BW'(1);
  assign frame_done   = shift_en && last_bit;
  assign held_word    = shift_reg;

`ifdef CLB_CFG_PARITY_EN
  logic par_reg;

  // The parity bit never enters the data register, so it already holds the word.
  assign data_en    = shift_en && !last_bit;
  assign parity_ok  = par_reg ^ din;
  assign frame_word = shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (shift_en) begin
      par_reg <= last_bit ? 1'b0 : (par_reg ^ din);
    end
  end
`else
  // Last data bit bypasses the register so the word can be loaded on its own edge.
  assign data_en    = shift_en;
  assign parity_ok  = 1'b1;
  assign frame_word = shift_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      if (shift_en) bit_cnt_reg <= bit_cnt_next;
      if (data_en)  shift_reg   <= shift_next;
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: preamble hunt, frame count, frames out on valid/ready.
// Build option CLB_CFG_PARITY_EN enables per-frame odd parity and the sticky ERR state.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             K,
  input  logic             RSTN,
  input  logic             DIN,
  input  logic             DIN_EN,
  output logic             DIN_RDY,
  output logic [CFG_W-1:0] CFG_DATA,
  output logic [CNT_W-1:0] CFG_ADDR,
  output logic             CFG_VALID,
  input  logic             CFG_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int CB = $clog2(CNT_W);

  cfg_state_e       state_reg, state_next;
  logic [7:0]       win_reg, win_next;
  logic [CB-1:0]    cbit_reg, cbit_next;
  logic [CNT_W-1:0] n_reg, n_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] addr_reg, addr_next;
  logic [CFG_W-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             accept;
  logic             shift_en;
  logic             hold_free;
  logic             load_en;
  logic [CFG_W-1:0] load_word;
  logic             frame_done;
  logic             parity_ok;
  logic [CFG_W-1:0] frame_word;
  logic [CFG_W-1:0] held_word;

  assign DIN_RDY   = (state_reg == S_HUNT) || (state_reg == S_COUNT) || (state_reg == S_FRAME);
  assign accept    = DIN_EN && DIN_RDY;
  assign shift_en  = accept && (state_reg == S_FRAME);
  // The hold register can take a word on the same edge it hands one off.
  assign hold_free = !valid_reg || CFG_READY;

  clb_cfg_frame_shift #(
    .CFG_W(CFG_W)
  ) u_shift (
    .clk       (K),
    .rst_n     (RSTN),
    .shift_en  (shift_en),
    .din       (DIN),
    .frame_done(frame_done),
    .parity_ok (parity_ok),
    .frame_word(frame_word),
    .held_word (held_word)
  );

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    cbit_next  = cbit_reg;
    n_next     = n_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    load_en    = 1'b0;
    load_word  = '0;

    if (valid_reg && CFG_READY) valid_next = 1'b0;

    case (state_reg)
      S_HUNT: begin
        if (accept) begin
          win_next = {win_reg[6:0], DIN};
          if (win_next == PREAMBLE) begin
            state_next = S_COUNT;
            win_next   = '0;
            cbit_next  = '0;
          end
        end
      end
      S_COUNT: begin
        if (accept) begin
          n_next    = {n_reg[CNT_W-2:0], DIN};
          cbit_next = cbit_reg + CB'(1);
          if (cbit_reg == CB'(CNT_W - 1)) begin
            cbit_next = '0;
            if (n_next == '0) begin
              done_next  = 1'b1;
              state_next = S_HUNT;
            end else begin
              idx_next   = '0;
              state_next = S_FRAME;
            end
          end
        end
      end
      S_FRAME: begin
        if (frame_done) begin
          if (!parity_ok) begin
            err_next   = 1'b1;
            state_next = S_ERR;
          end else if (hold_free) begin
            load_en   = 1'b1;
            load_word = frame_word;
          end else begin
            state_next = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (valid_reg && CFG_READY) begin
          load_en   = 1'b1;
          load_word = held_word;
        end
      end
      S_DRAIN: begin
        if (valid_reg && CFG_READY) begin
          done_next  = 1'b1;
          state_next = S_HUNT;
        end
      end
      default: ;
    endcase

    if (load_en) begin
      valid_next = 1'b1;
      data_next  = load_word;
      addr_next  = idx_reg;
      if (idx_reg == n_reg - CNT_W'(1)) begin
        state_next = S_DRAIN;
      end else begin
        idx_next   = idx_reg + CNT_W'(1);
        state_next = S_FRAME;
      end
    end
  end

  always_ff @(posedge K or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= S_HUNT;
      win_reg   <= '0;
      cbit_reg  <= '0;
      n_reg     <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      cbit_reg  <= cbit_next;
      n_reg     <= n_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign CFG_DATA  = data_reg;
  assign CFG_ADDR  = addr_reg;
  assign CFG_VALID = valid_reg;
  assign BUSY      = (state_reg != S_HUNT);
  assign DONE      = done_reg;
  assign ERR       = err_reg;

endmodule

// File: doc/clb_cfg_loader.md
# clb_cfg_loader

Serial configuration loader for the CLB array. It hunts a serial bitstream for a preamble, then reads a frame count and that many fixed-width configuration frames. Each frame is checked and presented as a parallel word, with its CLB index, on a valid/ready port toward the CLB configuration registers. It is the write side of CLB configuration: it produces the select, LUT-contents and mode bits each CLB consumes.

## Interface
Parameters:
- CFG_W, 37: data bits per frame. Default layout is 10 mux-select, 6 input-select, 2 DQ-select, 16 LUT, 2 comb-option, 1 flop/latch.
- CNT_W, 8: width of the frame-count field and of CFG_ADDR.

Ports:
- K, in, 1: clock; all state updates on the rising edge.
- RSTN, in, 1: reset, asynchronous, active-low.
- DIN, in, 1: serial bitstream, MSB first.
- DIN_EN, in, 1: DIN qualifier.
- DIN_RDY, out, 1: loader accepts a bit this cycle.
- CFG_DATA, out, CFG_W: configuration word.
- CFG_ADDR, out, CNT_W: CLB index of CFG_DATA, 0-based.
- CFG_VALID, out, 1: CFG_DATA/CFG_ADDR valid.
- CFG_READY, in, 1: CLB array accepts the word.
- BUSY, out, 1: high when state is not HUNT.
- DONE, out, 1: one-cycle pulse when a load completes.
- ERR, out, 1: sticky parity error.

## Operation
- Bit acceptance: a bit is taken on an edge where DIN_EN && DIN_RDY. DIN_RDY is combinational: 1 in HUNT, COUNT and FRAME; 0 in STALL, DRAIN and ERR.
- HUNT: an 8-bit sliding window compares the accepted bits to PREAMBLE = 8'hB2. Overlapping matches count. A match moves to COUNT.
- COUNT: takes 8 bits, MSB first, as N.
  - N = 0: DONE pulses and the state returns to HUNT.
  - N > 0: the frame index clears to 0 and the state moves to FRAME.
- FRAME: shifts CFG_W data bits, then one parity bit.
  - Odd parity: the data bits plus the parity bit must contain an odd number of ones.
  - Good frame, hold register empty: the frame moves to the hold register (CFG_VALID=1, CFG_ADDR=index).
  - Good frame, hold register full: the state moves to STALL.
- Hold register: cleared on an edge with CFG_VALID && CFG_READY. CFG_DATA and CFG_ADDR stay stable while CFG_VALID && !CFG_READY.
- STALL: on the handshake edge the pending frame moves into the hold register, so CFG_VALID stays 1 and the next word is presented with no bubble. The state then returns to FRAME.
- Index: increments when a frame is delivered. When the delivered frame is frame N-1, the state moves to DRAIN instead of FRAME.
- DRAIN: waits for the final handshake. On that edge DONE=1 for one cycle and the state moves to HUNT.
- ERR: entered on a parity mismatch.
  - The bad frame is discarded.
  - Any already-held word is still delivered.
  - ERR=1 and DIN_RDY=0 until reset.
- Reset at any point discards any partial frame, the held word and the count.

## Timing
- Reset values: DIN_RDY=1, CFG_VALID=0, CFG_DATA=0, CFG_ADDR=0, BUSY=0, DONE=0, ERR=0, state HUNT.
- Latency: CFG_VALID rises in the cycle after the edge that accepts the last bit of a frame (the parity bit, or the last data bit when parity is compiled out).
- Throughput: one bit per cycle. With CFG_READY tied to 1, no stalls occur.
- ERR and DONE are registered.
- The DONE pulse coincides with CFG_VALID falling.

## Configuration
- CLB_CFG_PARITY_EN defined: frames are CFG_W+1 bits, parity is checked, and the ERR state is reachable.
- CLB_CFG_PARITY_EN undefined: frames are CFG_W bits, there is no check, and ERR is tied to 0.

## Structure
- Package clb_cfg_pkg holds:
  - CFG_W and CNT_W defaults
  - the PREAMBLE constant
  - the state enum (HUNT, COUNT, FRAME, STALL, DRAIN, ERR)
  - bit-offset constants for each field in the config word
- Sub-module clb_cfg_frame_shift contains the shift register, bit counter and parity accumulator. It outputs frame_done and parity_ok.

## Test plan
- Basic load: stream 0xB2, N=2, then frames 37'h0_0000_0116 and 37'h1_FFFF_FFFF with correct parity, CFG_READY=1 → two words at CFG_ADDR 0 and 1, then a DONE pulse and BUSY=0.
- Preamble hunt: noise bits 1011_1011_0010 then a valid stream → lock on the overlapping 0xB2 match. A corrupted preamble 0xB3 → stays in HUNT.
- Backpressure: hold CFG_READY=0 through two frames → DIN_RDY=0 in STALL, CFG_DATA stable. Release → the second word appears on the edge after the first handshake, with no bubble.
- Parity error: flip the parity bit of frame 1 of N=3 → frame 0 delivered, ERR=1, DIN_RDY=0 persists, no DONE.
- Zero count: 0xB2 then N=0 → DONE pulse the cycle after the last count bit, no CFG_VALID.
- Reset mid-frame: assert RSTN=0 after 20 data bits → all outputs return to their reset values. A new full stream then loads correctly from index 0.
